// File: rtl/branch_spec_ctrl_pkg.sv
// Shared types for the branch speculation controller: FSM states and the branch tag type.
package branch_spec_ctrl_pkg;

   localparam int NR_BRANCHES_DEFAULT = 4;
   localparam int TAG_W               = $clog2(NR_BRANCHES_DEFAULT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      REDIRECT = 2'd2
   } branch_ctrl_state_e;

   typedef logic [TAG_W-1:0] branch_tag_t;

endpackage

// File: rtl/branch_spec_ctrl_if.sv
// Issue / branch-unit / frontend signals of the speculation controller.
// master = the surrounding pipeline, slave = the controller itself.
interface branch_spec_ctrl_if #(
   parameter int NR_BRANCHES = 4,
   parameter int VLEN        = 64
);
   import branch_spec_ctrl_pkg::*;

   localparam int TW = $clog2(NR_BRANCHES);
   localparam int CW = $clog2(NR_BRANCHES + 1);

   logic                   alloc_valid_i;
   logic                   alloc_ready_o;
   logic [TW-1:0]          alloc_tag_o;
   logic                   resolve_valid_i;
   logic [TW-1:0]          resolve_tag_i;
   logic                   resolve_mispredict_i;
   logic [VLEN-1:0]        resolve_target_i;
   logic                   flush_o;
   logic [NR_BRANCHES-1:0] kill_mask_o;
   logic                   redirect_valid_o;
   logic [VLEN-1:0]        redirect_pc_o;
   logic                   redirect_ready_i;
   logic [CW-1:0]          inflight_cnt_o;
   logic                   protocol_err_o;

   modport master (
      output alloc_valid_i, resolve_valid_i, resolve_tag_i, resolve_mispredict_i,
             resolve_target_i, redirect_ready_i,
      input  alloc_ready_o, alloc_tag_o, flush_o, kill_mask_o, redirect_valid_o,
             redirect_pc_o, inflight_cnt_o, protocol_err_o
   );

   modport slave (
      input  alloc_valid_i, resolve_valid_i, resolve_tag_i, resolve_mispredict_i,
             resolve_target_i, redirect_ready_i,
      output alloc_ready_o, alloc_tag_o, flush_o, kill_mask_o, redirect_valid_o,
             redirect_pc_o, inflight_cnt_o, protocol_err_o
   );

endinterface

// File: rtl/branch_spec_ctrl_tag_ring.sv
// Circular tag queue: head/tail pointers, per-tag valid bits and an occupancy count.
// Updates land on the next edge; o_valid_nxt exposes the vector those updates will produce.
module branch_tag_ring #(
   parameter int NR_BRANCHES = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               i_alloc,
   input  logic                               i_free,
   input  logic                               i_clear,
   output logic [$clog2(NR_BRANCHES)-1:0]     o_head,
   output logic [$clog2(NR_BRANCHES)-1:0]     o_tail,
   output logic [NR_BRANCHES-1:0]             o_valid,
   output logic [NR_BRANCHES-1:0]             o_valid_nxt,
   output logic [$clog2(NR_BRANCHES+1)-1:0]   o_count
);
   import branch_spec_ctrl_pkg::*;

   localparam int TW = $clog2(NR_BRANCHES);
   localparam int CW = $clog2(NR_BRANCHES + 1);

   logic [TW-1:0]          r_head;
   logic [TW-1:0]          r_tail;
   logic [NR_BRANCHES-1:0] r_valid;
   logic [CW-1:0]          r_count;
   logic [NR_BRANCHES-1:0] w_valid_nxt;

   // The caller only allocates below full, so alloc and free never target the same slot.
   always_comb begin
      w_valid_nxt = r_valid;
      if (i_clear) begin
         w_valid_nxt = '0;
      end else begin
         if (i_free)  w_valid_nxt[r_head] = 1'b0;
         if (i_alloc) w_valid_nxt[r_tail] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_valid <= '0;
         r_count <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         if (i_clear) begin
            r_head  <= r_tail;
            r_count <= '0;
         end else begin
            if (i_free)  r_head <= r_head + TW'(1);
            if (i_alloc) r_tail <= r_tail + TW'(1);
            r_count <= r_count + CW'(i_alloc) - CW'(i_free);
         end
      end
   end

   assign o_head      = r_head;
   assign o_tail      = r_tail;
   assign o_valid     = r_valid;
   assign o_valid_nxt = w_valid_nxt;
   assign o_count     = r_count;

endmodule

// File: rtl/branch_spec_ctrl.sv
// Branch speculation controller: in-order tag allocation, head-only resolve, and on a
// mispredict a one-cycle flush followed by a held redirect until the frontend accepts it.
module branch_spec_ctrl
   import branch_spec_ctrl_pkg::*;
#(
   parameter int NR_BRANCHES = 4,
   parameter int VLEN        = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
   branch_spec_ctrl_if.slave  bus
);

   localparam int TW = $clog2(NR_BRANCHES);
   localparam int CW = $clog2(NR_BRANCHES + 1);

   localparam logic [1:0] S_IDLE     = IDLE;
   localparam logic [1:0] S_FLUSH    = FLUSH;
   localparam logic [1:0] S_REDIRECT = REDIRECT;

   logic [1:0]             r_state;
   logic [NR_BRANCHES-1:0] r_kill_mask;
   logic [VLEN-1:0]        r_redirect_pc;
   logic                   r_protocol_err;

   logic                   w_idle;
   logic                   w_alloc_ready;
   logic                   w_alloc_fire;
   logic                   w_res_hit;
   logic                   w_res_ok;
   logic                   w_res_bad;
   logic                   w_clear;
   logic [TW-1:0]          w_head;
   logic [TW-1:0]          w_tail;
   logic [NR_BRANCHES-1:0] w_valid;
   logic [NR_BRANCHES-1:0] w_valid_nxt;
   logic [CW-1:0]          w_count;

   assign w_idle        = (r_state == S_IDLE);
   assign w_alloc_ready = w_idle && (w_count < CW'(NR_BRANCHES));
   assign w_alloc_fire  = bus.alloc_valid_i && w_alloc_ready;
   assign w_res_hit     = (bus.resolve_tag_i == w_head) && w_valid[w_head];
   assign w_res_ok      = bus.resolve_valid_i && w_idle && w_res_hit;
   assign w_res_bad     = bus.resolve_valid_i && !w_res_ok;
   assign w_clear       = (r_state == S_FLUSH);

   branch_tag_ring #(
      .NR_BRANCHES (NR_BRANCHES)
   ) u_ring (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_alloc     (w_alloc_fire),
      .i_free      (w_res_ok),
      .i_clear     (w_clear),
      .o_head      (w_head),
      .o_tail      (w_tail),
      .o_valid     (w_valid),
      .o_valid_nxt (w_valid_nxt),
      .o_count     (w_count)
   );

   // Kill mask is the post-update valid vector: includes a same-cycle alloc, excludes the resolved tag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state        <= S_IDLE;
         r_kill_mask    <= '0;
         r_redirect_pc  <= '0;
         r_protocol_err <= 1'b0;
      end else begin
         if (w_res_bad) r_protocol_err <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_res_ok && bus.resolve_mispredict_i) begin
                  r_kill_mask   <= w_valid_nxt;
                  r_redirect_pc <= bus.resolve_target_i;
                  r_state       <= S_FLUSH;
               end
            end
            S_FLUSH:    r_state <= S_REDIRECT;
            S_REDIRECT: if (bus.redirect_ready_i) r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.alloc_ready_o    = w_alloc_ready;
   assign bus.alloc_tag_o      = w_tail;
   assign bus.flush_o          = (r_state == S_FLUSH);
   assign bus.kill_mask_o      = (r_state == S_FLUSH) ? r_kill_mask : '0;
   assign bus.redirect_valid_o = (r_state == S_REDIRECT);
   assign bus.redirect_pc_o    = r_redirect_pc;
   assign bus.inflight_cnt_o   = w_count;
   assign bus.protocol_err_o   = r_protocol_err;

endmodule

// File: tb/tb_branch_spec_ctrl.sv
// Directed bench for branch_spec_ctrl: a queue-based reference model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_branch_spec_ctrl;

   localparam int N    = 4;
   localparam int VLEN = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_spec_ctrl_if #(.NR_BRANCHES(N), .VLEN(VLEN)) bus ();

   branch_spec_ctrl #(.NR_BRANCHES(N), .VLEN(VLEN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-flight tags as an ordered list; phase 0=normal, 1=flushing, 2=redirecting.
   int              q[$];
   int              m_tail  = 0;
   int              m_phase = 0;
   logic [N-1:0]    m_kill  = '0;
   logic [VLEN-1:0] m_pc    = '0;
   bit              m_perr  = 1'b0;

   always @(posedge clk) begin
      bit fire;
      bit ok;
      if (rst) begin
         q.delete();
         m_tail  = 0;
         m_phase = 0;
         m_kill  = '0;
         m_pc    = '0;
         m_perr  = 1'b0;
      end else begin
         ok = bus.resolve_valid_i && (m_phase == 0) && (q.size() > 0) &&
              (q[0] == int'(bus.resolve_tag_i));
         if (bus.resolve_valid_i && !ok) m_perr = 1'b1;
         case (m_phase)
            0: begin
               fire = bus.alloc_valid_i && (q.size() < N);
               if (ok) void'(q.pop_front());
               if (fire) begin
                  q.push_back(m_tail);
                  m_tail = (m_tail + 1) % N;
               end
               if (ok && bus.resolve_mispredict_i) begin
                  m_kill = '0;
                  foreach (q[i]) m_kill[q[i]] = 1'b1;
                  m_pc    = bus.resolve_target_i;
                  m_phase = 1;
               end
            end
            1: begin
               q.delete();
               m_phase = 2;
            end
            default: if (bus.redirect_ready_i) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("alloc_ready", 64'(bus.alloc_ready_o), 64'((m_phase == 0) && (q.size() < N)));
         chk("alloc_tag", 64'(bus.alloc_tag_o), 64'(m_tail));
         chk("inflight_cnt", 64'(bus.inflight_cnt_o), 64'(q.size()));
         chk("flush", 64'(bus.flush_o), 64'(m_phase == 1));
         chk("kill_mask", 64'(bus.kill_mask_o), (m_phase == 1) ? 64'(m_kill) : 64'(0));
         chk("redirect_valid", 64'(bus.redirect_valid_o), 64'(m_phase == 2));
         if (m_phase == 2) chk("redirect_pc", 64'(bus.redirect_pc_o), 64'(m_pc));
         chk("protocol_err", 64'(bus.protocol_err_o), 64'(m_perr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_valid_i        = 1'b0;
      bus.resolve_valid_i      = 1'b0;
      bus.resolve_tag_i        = '0;
      bus.resolve_mispredict_i = 1'b0;
      bus.resolve_target_i     = '0;
      bus.redirect_ready_i     = 1'b0;
   endtask

   task automatic resolve(input int tag, input bit mis, input logic [VLEN-1:0] tgt);
      bus.resolve_valid_i      = 1'b1;
      bus.resolve_tag_i        = 2'(tag);
      bus.resolve_mispredict_i = mis;
      bus.resolve_target_i     = tgt;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick();
      cmp_en = 1'b1;
      chk("reset alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("reset inflight_cnt", 64'(bus.inflight_cnt_o), 64'd0);
      chk("reset flush", 64'(bus.flush_o), 64'd0);
      chk("reset redirect_valid", 64'(bus.redirect_valid_o), 64'd0);
      tick();
      rst = 1'b0;

      // Fill all four tags, then wrap: the freed tag 0 is the next one handed out.
      for (int i = 0; i < N; i++) begin
         bus.alloc_valid_i = 1'b1;
         chk("fill alloc_tag", 64'(bus.alloc_tag_o), 64'(i));
         tick();
      end
      bus.alloc_valid_i = 1'b0;
      chk("full alloc_ready", 64'(bus.alloc_ready_o), 64'd0);
      chk("full inflight_cnt", 64'(bus.inflight_cnt_o), 64'd4);
      bus.alloc_valid_i = 1'b1;
      resolve(0, 1'b0, '0);
      tick();
      bus.resolve_valid_i = 1'b0;
      chk("wrap alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("wrap alloc_tag", 64'(bus.alloc_tag_o), 64'd0);
      tick();
      bus.alloc_valid_i = 1'b0;
      chk("wrap inflight_cnt", 64'(bus.inflight_cnt_o), 64'd4);
      resolve(1, 1'b0, '0);
      tick();
      bus.alloc_valid_i = 1'b1;
      resolve(2, 1'b0, '0);
      chk("simul alloc_tag", 64'(bus.alloc_tag_o), 64'd1);
      tick();
      idle_inputs();
      chk("simul inflight_cnt", 64'(bus.inflight_cnt_o), 64'd3);

      // Mispredict on tag 0 with tags 1,2 younger; redirect held for three cycles.
      do_reset();
      bus.alloc_valid_i = 1'b1;
      repeat (3) tick();
      bus.alloc_valid_i = 1'b0;
      resolve(0, 1'b1, 64'h8000_1000);
      tick();
      idle_inputs();
      chk("mis flush", 64'(bus.flush_o), 64'd1);
      chk("mis kill_mask", 64'(bus.kill_mask_o), 64'b0110);
      chk("mis alloc_ready", 64'(bus.alloc_ready_o), 64'd0);
      tick();
      chk("redir valid", 64'(bus.redirect_valid_o), 64'd1);
      chk("redir pc", 64'(bus.redirect_pc_o), 64'h8000_1000);
      repeat (3) begin
         tick();
         chk("redir hold pc", 64'(bus.redirect_pc_o), 64'h8000_1000);
      end
      bus.redirect_ready_i = 1'b1;
      tick();
      bus.redirect_ready_i = 1'b0;
      chk("post redir valid", 64'(bus.redirect_valid_o), 64'd0);
      chk("post redir alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("post redir inflight_cnt", 64'(bus.inflight_cnt_o), 64'd0);

      // Mispredict coinciding with an alloc of tag 1; alloc during the flush is refused.
      do_reset();
      bus.alloc_valid_i = 1'b1;
      tick();
      resolve(0, 1'b1, 64'h0000_0000_0000_1234);
      tick();
      bus.resolve_valid_i = 1'b0;
      chk("coalloc kill_mask", 64'(bus.kill_mask_o), 64'b0010);
      chk("coalloc flush alloc_ready", 64'(bus.alloc_ready_o), 64'd0);
      tick();
      bus.alloc_valid_i = 1'b0;
      chk("coalloc inflight_cnt", 64'(bus.inflight_cnt_o), 64'd0);
      chk("coalloc redir pc", 64'(bus.redirect_pc_o), 64'h1234);
      bus.redirect_ready_i = 1'b1;
      tick();
      idle_inputs();

      // Out-of-order resolve is flagged and ignored.
      do_reset();
      bus.alloc_valid_i = 1'b1;
      repeat (3) tick();
      bus.alloc_valid_i = 1'b0;
      resolve(2, 1'b1, 64'h4444);
      tick();
      idle_inputs();
      chk("badtag protocol_err", 64'(bus.protocol_err_o), 64'd1);
      chk("badtag inflight_cnt", 64'(bus.inflight_cnt_o), 64'd3);
      chk("badtag flush", 64'(bus.flush_o), 64'd0);
      tick();
      chk("badtag sticky", 64'(bus.protocol_err_o), 64'd1);

      // Reset while redirecting returns everything to idle with no trailing flush/redirect.
      resolve(0, 1'b1, 64'hdead_beef);
      tick();
      idle_inputs();
      tick();
      chk("rstredir valid before", 64'(bus.redirect_valid_o), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstredir valid", 64'(bus.redirect_valid_o), 64'd0);
      chk("rstredir flush", 64'(bus.flush_o), 64'd0);
      chk("rstredir alloc_ready", 64'(bus.alloc_ready_o), 64'd1);
      chk("rstredir inflight_cnt", 64'(bus.inflight_cnt_o), 64'd0);
      chk("rstredir protocol_err", 64'(bus.protocol_err_o), 64'd0);
      repeat (3) begin
         tick();
         chk("rstredir no flush", 64'(bus.flush_o), 64'd0);
      end

      @(posedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
